// File: rtl/seq_right_shifter.sv
// Multi-cycle 16-bit right shifter: advances up to three bit positions per cycle,
// with zero or sign fill, and strobes done for one cycle when the result is ready.
module seq_right_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] operand,
  input  logic [3:0]  shift_amt,
  input  logic        arith,
  output logic [15:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] work_r;
  logic [3:0]  remaining_r;
  logic        fill_mode_r;
  logic        sign_r;
  logic [15:0] result_r;
  logic        busy_r;
  logic        done_r;

  logic [1:0]  step_s;
  logic        fill_s;
  logic [15:0] shifted_s;
  logic        last_step_s;

  // Shift v right by step (0..3), feeding fill into the vacated MSBs.
  function automatic logic [15:0] shift_fill(input logic [15:0] v,
                                             input logic [1:0]  step,
                                             input logic        fill);
    logic [15:0] r;
    case (step)
      2'd0:    r = v;
      2'd1:    r = {fill, v[15:1]};
      2'd2:    r = {{2{fill}}, v[15:2]};
      2'd3:    r = {{3{fill}}, v[15:3]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Per-cycle step size, fill bit and next work value.
  always_comb begin
    step_s      = 2'd0;
    fill_s      = 1'b0;
    shifted_s   = work_r;
    last_step_s = 1'b0;
    if (remaining_r > 4'd3) begin
      step_s = 2'd3;
    end else begin
      step_s = remaining_r[1:0];
    end
    fill_s      = fill_mode_r & sign_r;
    shifted_s   = shift_fill(work_r, step_s, fill_s);
    last_step_s = (remaining_r == {2'b00, step_s});
  end

  // Control FSM with registered datapath and outputs; reset dominates start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      work_r      <= 16'h0000;
      remaining_r <= 4'd0;
      fill_mode_r <= 1'b0;
      sign_r      <= 1'b0;
      result_r    <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            work_r      <= operand;
            remaining_r <= shift_amt;
            fill_mode_r <= arith;
            sign_r      <= operand[15];
            busy_r      <= 1'b1;
            state_r     <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Start is deliberately ignored here; only the shift advances.
          work_r      <= shifted_s;
          remaining_r <= remaining_r - {2'b00, step_s};
          if (last_step_s) begin
            result_r <= shifted_s;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Randomized and directed bench for seq_right_shifter against a plain arithmetic
// model of the shift result and cycle count.
module tb_seq_right_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] operand;
  logic [3:0]  shift_amt;
  logic        arith;
  logic [15:0] result;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_result = 16'h0000;

  seq_right_shifter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .operand  (operand),
    .shift_amt(shift_amt),
    .arith    (arith),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input logic [15:0] op, input int amt, input bit ar);
    logic signed [15:0] s;
    s = op;
    if (ar) return 16'(s >>> amt);
    return op >> amt;
  endfunction

  function automatic int model_cycles(input int amt);
    if (amt == 0) return 1;
    return (amt + 2) / 3;
  endfunction

  // Issue a request at the current negedge and follow it to its done strobe.
  // Returns at the negedge where done is visible.
  task automatic do_op(input logic [15:0] op, input int amt, input bit ar, input bit intrude);
    int cycles;
    int n_exp;
    logic [15:0] exp;
    exp   = model_result(op, amt, ar);
    n_exp = model_cycles(amt);
    start = 1'b1; operand = op; shift_amt = 4'(amt); arith = ar;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("done_after_accept", {31'd0, done}, 32'd0);
    if (intrude) begin
      start = 1'b1; operand = 16'hFFFF; shift_amt = 4'd1; arith = 1'b1;
    end
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      start = 1'b0; operand = $urandom(); shift_amt = $urandom(); arith = $urandom();
      cycles++;
      if (!done) begin
        if (busy !== 1'b1) chk("busy_during_shift", {31'd0, busy}, 32'd1);
        if (result !== last_result) chk("result_hold_shift", {16'd0, result}, {16'd0, last_result});
      end
    end
    chk("shift_cycles", cycles, n_exp);
    chk("result", {16'd0, result}, {16'd0, exp});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    last_result = exp;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_drop", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("result_hold_idle", {16'd0, result}, {16'd0, last_result});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operand = 16'h0000; shift_amt = 4'd0; arith = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Directed cases from the requirement examples.
    do_op(16'h8888, 4, 1'b0, 1'b0);  chk("ex_0888", {16'd0, result}, 32'h0888); idle_check();
    do_op(16'h8888, 4, 1'b1, 1'b0);  chk("ex_F888", {16'd0, result}, 32'hF888); idle_check();
    do_op(16'h8000, 15, 1'b1, 1'b0); chk("ex_FFFF", {16'd0, result}, 32'hFFFF); idle_check();
    do_op(16'h7777, 0, 1'b0, 1'b0);  chk("ex_7777", {16'd0, result}, 32'h7777); idle_check();
    do_op(16'h7777, 3, 1'b1, 1'b0);  chk("ex_0EEE", {16'd0, result}, 32'h0EEE); idle_check();
    do_op(16'hBBBB, 15, 1'b0, 1'b1); chk("ex_ignore", {16'd0, result}, 32'h0001);
    // Back-to-back: new request issued during the done cycle.
    do_op(16'hFFFF, 8, 1'b0, 1'b0);  chk("ex_00FF", {16'd0, result}, 32'h00FF); idle_check();
    do_op(16'h7FFF, 15, 1'b1, 1'b0); idle_check();
    do_op(16'hC001, 15, 1'b0, 1'b0); idle_check();

    // Abort with reset during the second shift cycle of a 9-bit shift.
    start = 1'b1; operand = 16'h1234; shift_amt = 4'd9; arith = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    last_result = 16'h0000;
    reset = 1'b0;
    do_op(16'hA5A5, 5, 1'b1, 1'b0); idle_check();

    // Randomized operations, mixing idle gaps and back-to-back requests.
    for (int i = 0; i < 60; i++) begin
      do_op(16'($urandom()), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 Clk  input  1  system clock; all state changes on the rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clk.
REQ-003 Start  input  1  request pulse; sampled on each rising edge; honoured only as in REQ-011.
REQ-004 Operand  input  16  value to shift; captured on the accepting edge.
REQ-005 ShiftAmt  input  4  right-shift distance, 0..15; captured on the accepting edge.
REQ-006 Arith  input  1  fill mode, captured on the accepting edge: 1 = sign fill (copy of Operand[15]), 0 = zero fill.
REQ-007 Result  output  16  registered shifted value; valid while Done=1 and held until the next completion.
REQ-008 Busy  output  1  registered; high while an operation is in progress.
REQ-009 Done  output  1  registered; single-cycle completion strobe.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-011 A Start sampled high in IDLE or DONE SHALL be accepted.
- On acceptance: capture Operand into the work register, ShiftAmt into Remaining, and Arith into FillMode.
- Then enter SHIFT with Busy=1.
REQ-012 A Start sampled high in SHIFT SHALL be ignored, with no effect on state, work register, Remaining, FillMode or outputs.
REQ-013 Each SHIFT cycle SHALL apply Step = min(Remaining, 3) in one edge.
- Work register is shifted right by Step.
- Vacated MSBs are filled with zeros (FillMode=0) or with the captured sign bit (FillMode=1).
- Remaining decreases by Step.
REQ-014 When Remaining equals Step, the same edge SHALL load Result with the final shifted value, set Done=1, clear Busy and enter DONE.
REQ-015 ShiftAmt=0 SHALL spend exactly one SHIFT cycle with Step=0, so that Result = Operand.
REQ-016 Number of SHIFT cycles N SHALL be max(1, ceil(ShiftAmt/3)); for example 0->1, 3->1, 4->2, 15->5.
REQ-017 Timing relative to the accepting edge k:
- Busy SHALL be high after edge k through edge k+N.
- Done SHALL be high for exactly the cycle following edge k+N.
REQ-018 DONE SHALL last one cycle.
- Without Start: go to IDLE and clear Done.
- With Start: accept per REQ-011, clear Done, set Busy (back-to-back operation).
REQ-019 Result SHALL change only on a completion edge (REQ-014) or on reset; it SHALL hold its value in IDLE and SHIFT.
REQ-020 A sign-fill shift of 15 SHALL yield 0xFFFF or 0x0000 according to the sign; a zero-fill shift of 15 SHALL yield Operand[15] in bit 0 and zeros elsewhere.
REQ-021 Shifting SHALL be 16-bit only; no bits SHALL enter from outside Operand other than fill bits.

Reset
REQ-022 Reset=1 at a rising edge SHALL force state=IDLE, Result=0x0000, Busy=0, Done=0, Remaining=0 and work register=0x0000.
REQ-023 Reset SHALL take priority over Start on the same edge; Start SHALL be ignored while Reset=1.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation with no Done pulse and no Result update beyond the cleared value.
REQ-025 After Reset deasserts, a Start on the first subsequent edge SHALL be accepted normally.

Verification
REQ-026 Operand=0x8888, ShiftAmt=4, Arith=0 -> Busy for 2 cycles, then Done with Result=0x0888.
REQ-027 Operand=0x8888, ShiftAmt=4, Arith=1 -> Done after 2 SHIFT cycles with Result=0xF888; Operand=0x8000, ShiftAmt=15, Arith=1 -> 5 SHIFT cycles, Result=0xFFFF.
REQ-028 Operand=0x7777, ShiftAmt=0 -> 1 SHIFT cycle, Done with Result=0x7777; ShiftAmt=3, Arith=1 -> 1 SHIFT cycle, Result=0x0EEE.
REQ-029 Start ShiftAmt=15 on 0xBBBB, Arith=0, then pulse Start with 0xFFFF during SHIFT -> second request ignored, Done once with Result=0x0001.
REQ-030 Start during the Done cycle (0xFFFF, ShiftAmt=8, Arith=0) -> Done drops, Busy rises the next cycle, second Done after 3 SHIFT cycles with Result=0x00FF.
REQ-031 Assert Reset during the second SHIFT cycle of a ShiftAmt=9 operation -> Busy=0, Done=0, Result=0x0000 next cycle; Done never pulses for that operation.
